// File: rtl/arb8way16.sv
// 8-way round-robin arbiter with a registered one-word output holding stage.
// Optional ARB_LOCK_EN adds a per-requester lock input that re-grants the last winner.
//
// state | meaning
// IDLE  | no word held, out_valid=0; any request is arbitrated and captured
// HOLD  | word held in out_data, out_valid=1; arbitrates only on handshake
module arb8way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [7:0]       req,
`ifdef ARB_LOCK_EN
  input  logic [7:0]       lock,
`endif
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       rr_idx;
  logic [2:0]       win_idx;
  logic [2:0]       cand;
  logic             rr_found;
  logic             any_req;
  logic             arb_en;
  logic             do_grant;
  logic [WIDTH-1:0] in_word [8];

  assign in_word[0] = in0;
  assign in_word[1] = in1;
  assign in_word[2] = in2;
  assign in_word[3] = in3;
  assign in_word[4] = in4;
  assign in_word[5] = in5;
  assign in_word[6] = in6;
  assign in_word[7] = in7;

  assign any_req = |req;

  // Search upward from ptr+1; the i=8 candidate wraps back to ptr itself.
  always_comb begin
    rr_idx   = ptr;
    rr_found = 1'b0;
    cand     = ptr;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!rr_found && req[cand]) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic lock_active;
  logic lock_hit;

  // ptr always names the last winner, so it doubles as the locked index.
  assign lock_hit = lock_active && req[ptr] && lock[ptr];
  assign win_idx  = lock_hit ? ptr : rr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
    end else if (do_grant) begin
      lock_active <= lock[win_idx];
    end
  end
`else
  assign win_idx = rr_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (any_req) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          arb_en = 1'b1;
          if (!any_req) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign do_grant  = arb_en && any_req && !reset;
  assign grant     = do_grant ? (8'b0000_0001 << win_idx) : 8'h00;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      sel      <= 3'd0;
      ptr      <= 3'd7;
    end else if (do_grant) begin
      out_data <= in_word[win_idx];
      sel      <= win_idx;
      ptr      <= win_idx;
    end
  end

endmodule

// File: doc/arb8way16.md
ARB8WAY16 -- requirements
Module: arb8way16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data width of every requester and output data port.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports in0..in7  input  WIDTH each  requester data, held stable by requester k while req[k]=1.
REQ-005 SHALL have port req  input  8  request per requester, bit k for in k.
REQ-006 SHALL have port grant  output  8  one-hot, one-cycle pulse; grant[k]=1 means in k was captured at that edge.
REQ-007 SHALL have port sel  output  3  index of the requester whose word is held in out_data.
REQ-008 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both 1.

Function
REQ-011 SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 SHALL, in IDLE with req!=0, select the winner, load out_data<=in[winner] and sel<=winner, assert grant[winner] combinationally in that cycle, and enter HOLD at the edge.
REQ-013 SHALL, in IDLE with req=0, stay in IDLE with grant=0.
REQ-014 SHALL, in HOLD without handshake, keep out_data, sel and out_valid unchanged, grant=0, no arbitration.
REQ-015 SHALL, in HOLD with handshake and req!=0, arbitrate and capture a new word in the same cycle (back-to-back, one word per cycle), remaining in HOLD.
REQ-016 SHALL, in HOLD with handshake and req=0, enter IDLE and clear out_valid.
REQ-017 SHALL select the winner round-robin: first set req bit searching upward from ptr+1 modulo 8 (7 wraps to 0).
REQ-018 SHALL update ptr to the winner index on every grant; ptr unchanged otherwise.
REQ-019 SHALL assert at most one grant bit per cycle; grant is never asserted while out_valid=1 and out_ready=0.
REQ-020 SHALL allow a requester to drop req before grant; no grant is issued to it and no state changes result.
REQ-021 SHALL give latency of one cycle from grant to out_valid; out_data never changes while out_valid=1 and out_ready=0.
REQ-022 SHALL guarantee any continuously asserted requester is granted within 8 grants.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, force state IDLE, out_valid=0, out_data=0, sel=0, ptr=7 (requester 0 highest priority next), overriding any handshake or request that cycle.
REQ-024 SHALL hold grant=0 in any cycle where reset=1; a word held mid-transfer is discarded.

Configuration
REQ-025 SHALL, with ARB_LOCK_EN defined, add port lock  input  8  where lock[k]=1 at capture of requester k makes the next arbitration grant k again if req[k]=1, bypassing round-robin, ptr still set to k.
REQ-026 SHALL, with ARB_LOCK_EN defined, resume round-robin from ptr+1 once the locked requester deasserts req or lock.
REQ-027 SHALL, without ARB_LOCK_EN, have no lock port and pure round-robin behaviour.

Verification
REQ-028 SHALL cover: reset, then req=8'b0000_0001, in0=16'h1234, out_ready=1 -> grant=8'h01 same cycle; next cycle out_valid=1, out_data=16'h1234, sel=0.
REQ-029 SHALL cover: req=8'hFF held, out_ready=1 -> grant sequence 01,02,04,...,80,01 on consecutive cycles, sel 0..7 then 0.
REQ-030 SHALL cover: word from in3=16'hBEEF captured, out_ready=0 for 5 cycles with req=8'hFF -> out_data=16'hBEEF, sel=3 stable, grant=0 throughout; out_ready=1 -> grant=8'h10 same cycle.
REQ-031 SHALL cover: ptr=6, req=8'b1000_0010 -> grant=8'h80; next arbitration with same req -> grant=8'h02 (wrap).
REQ-032 SHALL cover: reset asserted while out_valid=1, out_ready=1, req=8'hFF -> grant=0; after reset out_valid=0, out_data=0, first grant 8'h01.
REQ-033 SHALL cover (ARB_LOCK_EN): lock=8'h04, req=8'h0F, out_ready=1 -> grant=8'h04 repeated 4 cycles; lock=0 -> next grant=8'h08.
